fft_frame_loader: RTL and testbench

- Upstream feeder for the 16-entry FFT register file.
- Accepts a serial stream of 32-bit complex samples over a valid/ready handshake and assembles them into 16-sample frames.
- Presents each frame as a stable parallel data bank plus per-slot write addresses; with the bit-reversal map, the register file ends up in FFT input order.
- Double-buffered: frame k+1 fills while frame k is held for the FFT core.

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_frame_loader_if.sv | 24 ++
 rtl/fft_frame_loader.sv | 126 ++++++++++++
 tb/tb_fft_frame_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and address-map helper for the FFT frame loader.
package fft_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned N      = 16;
   localparam int unsigned ADDR_W = 4;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      WAIT = 1'b1
   } state_e;

   function automatic logic [ADDR_W-1:0] bitrev4(input logic [ADDR_W-1:0] x);
      return {x[0], x[1], x[2], x[3]};
   endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Serial sample stream (valid/ready with end-of-frame marker) into the FFT frame loader.
interface fft_frame_loader_if;
   import fft_pkg::*;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  in_last,
      output in_ready
   );

endinterface

// File: rtl/fft_frame_loader.sv
// Double-buffered 16-sample frame assembler feeding the FFT register file.
// Define FFT_LOADER_BITREV_EN for bit-reversed slot addresses; natural order otherwise.
module fft_frame_loader
   import fft_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   fft_frame_loader_if.slave     in_if,
   output logic [N*DATA_W-1:0]   data_flat,
   output logic [N*ADDR_W-1:0]   add_flat,
   output logic                  frame_valid,
   input  logic                  frame_ack,
   output logic                  frame_err,
   output logic [7:0]            frame_cnt
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   shadow_q [N];
   logic [DATA_W-1:0]   shadow_d [N];
   logic [DATA_W-1:0]   bank_q [N];
   logic [DATA_W-1:0]   bank_d [N];
   logic                fv_q, fv_d;
   logic                err_q, err_d;
   logic [7:0]          fcnt_q, fcnt_d;
   logic                ready_q, ready_d;
   logic                xfer;
   logic                commit;

   // ready_q is only ever high in FILL, so it alone qualifies a transfer.
   assign xfer = in_if.in_valid && ready_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      bank_d   = bank_q;
      fv_d     = fv_q;
      err_d    = 1'b0;
      fcnt_d   = fcnt_q;
      commit   = 1'b0;

      unique case (state_q)
         FILL: begin
            if (xfer) begin
               if (cnt_q != ADDR_W'(N - 1)) begin
                  if (in_if.in_last) begin
                     err_d = 1'b1;
                     cnt_d = '0;
                  end else begin
                     shadow_d[cnt_q] = in_if.in_data;
                     cnt_d           = cnt_q + 1'b1;
                  end
               end else if (!in_if.in_last) begin
                  err_d = 1'b1;
                  cnt_d = '0;
               end else if (!fv_q || frame_ack) begin
                  for (int i = 0; i < N - 1; i++) begin
                     bank_d[i] = shadow_q[i];
                  end
                  bank_d[N-1] = in_if.in_data;
                  fv_d        = 1'b1;
                  fcnt_d      = fcnt_q + 8'd1;
                  cnt_d       = '0;
                  commit      = 1'b1;
               end else begin
                  // Held frame not yet consumed: park the full shadow until ack.
                  shadow_d[N-1] = in_if.in_data;
                  cnt_d         = '0;
                  state_d       = WAIT;
               end
            end
            if (!commit && frame_ack && fv_q) begin
               fv_d = 1'b0;
            end
         end
         WAIT: begin
            if (frame_ack) begin
               bank_d  = shadow_q;
               fcnt_d  = fcnt_q + 8'd1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   assign ready_d = (state_d == FILL);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= FILL;
         cnt_q    <= '0;
         shadow_q <= '{default: '0};
         bank_q   <= '{default: '0};
         fv_q     <= 1'b0;
         err_q    <= 1'b0;
         fcnt_q   <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         bank_q   <= bank_d;
         fv_q     <= fv_d;
         err_q    <= err_d;
         fcnt_q   <= fcnt_d;
         ready_q  <= ready_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_slot
      assign data_flat[i*DATA_W +: DATA_W] = bank_q[i];
`ifdef FFT_LOADER_BITREV_EN
      assign add_flat[i*ADDR_W +: ADDR_W]  = bitrev4(ADDR_W'(i));
`else
      assign add_flat[i*ADDR_W +: ADDR_W]  = ADDR_W'(i);
`endif
   end

   assign in_if.in_ready = ready_q;
   assign frame_valid    = fv_q;
   assign frame_err      = err_q;
   assign frame_cnt      = fcnt_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomised bench for fft_frame_loader against a queue-based frame model.
module tb_fft_frame_loader;

   logic         clk;
   logic         rst;
   logic [511:0] data_flat;
   logic [63:0]  add_flat;
   logic         frame_valid;
   logic         frame_ack;
   logic         frame_err;
   logic [7:0]   frame_cnt;

   fft_frame_loader_if in_if ();

   fft_frame_loader dut (
      .CLK         (clk),
      .RST         (rst),
      .in_if       (in_if),
      .data_flat   (data_flat),
      .add_flat    (add_flat),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .frame_err   (frame_err),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: frames are queues; a full unconsumed frame is "held" while the bank is busy.
   logic [31:0] m_cur [$];
   logic [31:0] m_held [16];
   logic [31:0] m_bank [16];
   logic        m_wait;
   logic        m_fv;
   logic        m_err;
   logic        m_ready;
   logic [7:0]  m_cnt;

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_addr(input int i);
`ifdef FFT_LOADER_BITREV_EN
      return 4'(((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3));
`else
      return 4'(i);
`endif
   endfunction

   task automatic model_reset();
      m_cur.delete();
      for (int i = 0; i < 16; i++) begin
         m_bank[i] = '0;
         m_held[i] = '0;
      end
      m_wait  = 1'b0;
      m_fv    = 1'b0;
      m_err   = 1'b0;
      m_ready = 1'b0;
      m_cnt   = '0;
   endtask

   task automatic model_step(input logic v, input logic [31:0] d, input logic l, input logic ack);
      bit committed;
      committed = 0;
      m_err     = 1'b0;
      if (m_wait) begin
         if (ack) begin
            for (int i = 0; i < 16; i++) m_bank[i] = m_held[i];
            m_cnt++;
            m_wait = 1'b0;
         end
      end else begin
         if (v && m_ready) begin
            m_cur.push_back(d);
            if (l && m_cur.size() == 16) begin
               if (!m_fv || ack) begin
                  for (int i = 0; i < 16; i++) m_bank[i] = m_cur[i];
                  m_fv = 1'b1;
                  m_cnt++;
                  committed = 1;
               end else begin
                  for (int i = 0; i < 16; i++) m_held[i] = m_cur[i];
                  m_wait = 1'b1;
               end
               m_cur.delete();
            end else if (l || m_cur.size() == 16) begin
               m_err = 1'b1;
               m_cur.delete();
            end
         end
         if (!committed && ack) m_fv = 1'b0;
      end
      m_ready = !m_wait;
   endtask

   task automatic check_all();
      logic [511:0] exp_data;
      logic [63:0]  exp_add;
      for (int i = 0; i < 16; i++) begin
         exp_data[i*32 +: 32] = m_bank[i];
         exp_add[i*4 +: 4]    = exp_addr(i);
      end
      check_eq("frame_valid", 512'(frame_valid), 512'(m_fv));
      check_eq("in_ready", 512'(in_if.in_ready), 512'(m_ready));
      check_eq("frame_err", 512'(frame_err), 512'(m_err));
      check_eq("frame_cnt", 512'(frame_cnt), 512'(m_cnt));
      check_eq("data_flat", data_flat, exp_data);
      check_eq("add_flat", 512'(add_flat), 512'(exp_add));
   endtask

   // Called at a falling edge: drive, advance model across the next rising edge, check.
   task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic ack);
      in_if.in_valid = v;
      in_if.in_data  = d;
      in_if.in_last  = l;
      frame_ack      = ack;
      model_step(v, d, l, ack);
      @(negedge clk);
      check_all();
   endtask

   task automatic send_frame(input logic [31:0] base, input int len, input logic ack_on_last);
      for (int i = 0; i < len; i++) begin
         cycle(1'b1, base + 32'(i), (i == len - 1), ack_on_last && (i == len - 1));
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      rst = 1'b1;
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] d;
      logic        l;
      int          sz;
      rst            = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_data  = '0;
      in_if.in_last  = 1'b0;
      frame_ack      = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
`ifdef FFT_LOADER_BITREV_EN
      check_eq("add_slot1", 512'(add_flat[4 +: 4]), 512'(4'd8));
      check_eq("add_slot3", 512'(add_flat[12 +: 4]), 512'(4'd12));
`endif
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Single frame into an empty bank.
      send_frame(32'h0, 16, 1'b0);
      check_eq("single_slot5", 512'(data_flat[5*32 +: 32]), 512'(32'h5));
      check_eq("single_cnt", 512'(frame_cnt), 512'(8'd1));

      // Back-pressure: second frame parks until acked.
      send_frame(32'h100, 16, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hdead, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      check_eq("bp_slot5", 512'(data_flat[5*32 +: 32]), 512'(32'h105));
      check_eq("bp_cnt", 512'(frame_cnt), 512'(8'd2));

      // Ack coincident with final sample commits directly.
      send_frame(32'h200, 16, 1'b1);

      // Framing error on the 8th sample, then a clean frame.
      send_frame(32'h300, 8, 1'b0);
      send_frame(32'h400, 16, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1);

      for (int n = 0; n < 700; n++) begin
         if (n == 350) begin
            do_reset();
         end
         sz = m_cur.size();
         l  = (sz == 15) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 39) == 0);
         d  = $urandom;
         cycle($urandom_range(0, 9) < 7, d, l, $urandom_range(0, 4) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
